// File: rtl/axi_sram_pkg.sv
// rtl/axi_sram_pkg.sv - shared AXI widths, burst/resp encodings and FSM states for the SRAM read slave
package axi_sram_pkg;

  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DATA = 2'd2
  } state_t;

  // Low-bit wrap mask for a WRAP burst; zero means the length is not a legal wrap size.
  function automatic logic [AXI_LEN_W-1:0] wrap_mask(input logic [AXI_LEN_W-1:0] len);
    case (len)
      4'd1, 4'd3, 4'd7, 4'd15: wrap_mask = len;
      default:                 wrap_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next word address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
  import axi_sram_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic [AW-1:0]          addr,
  input  logic [AXI_LEN_W-1:0]   len,
  input  logic [AXI_BURST_W-1:0] burst,
  output logic [AW-1:0]          next_addr
);

  logic [AW-1:0] incr_addr;
  logic [AW-1:0] mask;

  assign incr_addr = addr + AW'(1);
  assign mask      = AW'(wrap_mask(len));

  // Illegal wrap lengths and the reserved encoding both fall through to INCR.
  always_comb begin
    next_addr = incr_addr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) && (mask != '0)) begin
      next_addr = (addr & ~mask) | (incr_addr & mask);
    end
  end

endmodule

// File: rtl/axi_sram_read_slave.sv
// rtl/axi_sram_read_slave.sv - AXI read-only slave serving bursts from a single-port SRAM
// One outstanding burst; every beat is a READ cycle (SRAM strobe) followed by a DATA cycle (R beat).
module axi_sram_read_slave
  import axi_sram_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 8,
  parameter int SRAM_AW = 14
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [ID_W-1:0]        ARID,
  input  logic [ADDR_W-1:0]      ARADDR,
  input  logic [AXI_LEN_W-1:0]   ARLEN,
  input  logic [AXI_SIZE_W-1:0]  ARSIZE,
  input  logic [AXI_BURST_W-1:0] ARBURST,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [ID_W-1:0]        RID,
  output logic [DATA_W-1:0]      RDATA,
  output logic [AXI_RESP_W-1:0]  RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic                   SRAM_CS,
  output logic                   SRAM_OE,
  output logic [SRAM_AW-1:0]     SRAM_A,
  input  logic [DATA_W-1:0]      SRAM_DO
);

  state_t                 state;
  logic [ID_W-1:0]        id_q;
  logic [SRAM_AW-1:0]     addr_q;
  logic [AXI_LEN_W-1:0]   len_q;
  logic [AXI_BURST_W-1:0] burst_q;
  logic [AXI_LEN_W-1:0]   beat_q;
  logic [SRAM_AW-1:0]     next_addr;

  // Upper address bits are pre-decoded upstream; size is always a full word.
  logic unused_bits;
  assign unused_bits = ^{ARSIZE, ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0]};

  axi_burst_addr_gen #(
    .AW (SRAM_AW)
  ) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
      SRAM_CS <= 1'b0;
      SRAM_OE <= 1'b0;
      SRAM_A  <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= BURST_INCR;
      beat_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ARVALID && ARREADY) begin
            id_q    <= ARID;
            addr_q  <= ARADDR[SRAM_AW+1:2];
            len_q   <= ARLEN;
            burst_q <= ARBURST;
            beat_q  <= '0;
            ARREADY <= 1'b0;
            SRAM_CS <= 1'b1;
            SRAM_OE <= 1'b1;
            SRAM_A  <= ARADDR[SRAM_AW+1:2];
            state   <= READ;
          end
        end

        READ: begin
          // Data is registered here so RDATA stays put however long RREADY stalls.
          RDATA   <= SRAM_DO;
          SRAM_CS <= 1'b0;
          SRAM_OE <= 1'b0;
          RVALID  <= 1'b1;
          RID     <= id_q;
          RRESP   <= RESP_OKAY;
          RLAST   <= (beat_q == len_q);
          state   <= DATA;
        end

        DATA: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
            if (RLAST) begin
              ARREADY <= 1'b1;
              state   <= IDLE;
            end else begin
              beat_q  <= beat_q + AXI_LEN_W'(1);
              addr_q  <= next_addr;
              SRAM_A  <= next_addr;
              SRAM_CS <= 1'b1;
              SRAM_OE <= 1'b1;
              state   <= READ;
            end
          end
        end

        default: begin
          state   <= IDLE;
          ARREADY <= 1'b1;
          RVALID  <= 1'b0;
          RLAST   <= 1'b0;
          SRAM_CS <= 1'b0;
          SRAM_OE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_read_slave.sv
// tb/tb_axi_sram_read_slave.sv - self-checking bench for axi_sram_read_slave
module tb_axi_sram_read_slave;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 8;
  localparam int SRAM_AW = 14;
  localparam int DEPTH   = 1 << SRAM_AW;

  logic               ACLK    = 1'b0;
  logic               ARESET  = 1'b1;
  logic [ID_W-1:0]    ARID    = '0;
  logic [ADDR_W-1:0]  ARADDR  = '0;
  logic [3:0]         ARLEN   = '0;
  logic [2:0]         ARSIZE  = 3'd2;
  logic [1:0]         ARBURST = 2'b01;
  logic               ARVALID = 1'b0;
  logic               ARREADY;
  logic [ID_W-1:0]    RID;
  logic [DATA_W-1:0]  RDATA;
  logic [1:0]         RRESP;
  logic               RLAST;
  logic               RVALID;
  logic               RREADY  = 1'b1;
  logic               SRAM_CS;
  logic               SRAM_OE;
  logic [SRAM_AW-1:0] SRAM_A;
  logic [DATA_W-1:0]  SRAM_DO;

  always #5 ACLK = ~ACLK;

  axi_sram_read_slave #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .SRAM_AW (SRAM_AW)
  ) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .ARID    (ARID),
    .ARADDR  (ARADDR),
    .ARLEN   (ARLEN),
    .ARSIZE  (ARSIZE),
    .ARBURST (ARBURST),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RID     (RID),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RLAST   (RLAST),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .SRAM_CS (SRAM_CS),
    .SRAM_OE (SRAM_OE),
    .SRAM_A  (SRAM_A),
    .SRAM_DO (SRAM_DO)
  );

  // SRAM contents; outside a strobed read the bus carries inverted junk.
  logic [DATA_W-1:0] mem [DEPTH];
  assign SRAM_DO = (SRAM_CS && SRAM_OE) ? mem[SRAM_A] : ~mem[SRAM_A];

  int errors = 0;
  int checks = 0;

  logic [SRAM_AW-1:0] obs_addr [$];
  logic [DATA_W-1:0]  obs_data [$];
  logic [ID_W-1:0]    obs_id   [$];
  logic               obs_last [$];
  logic [1:0]         obs_resp [$];
  int                 obs_cyc  [$];
  int                 first_valid_cyc;
  int                 hold_viol;
  int                 ar_busy;
  bit                 timed_out;

  function automatic logic [SRAM_AW-1:0] model_addr(input logic [ADDR_W-1:0] araddr, input int len,
                                                    input logic [1:0] burst, input int beat);
    int start, sz, base;
    start = int'(araddr[SRAM_AW+1:2]);
    if (burst == 2'b00) return SRAM_AW'(start);
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      sz   = len + 1;
      base = start - (start % sz);
      return SRAM_AW'(base + ((start + beat) % sz));
    end
    return SRAM_AW'((start + beat) % DEPTH);
  endfunction

  // Issues one AR and records every SRAM strobe and R beat; judging is left to the callers.
  task automatic do_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len,
                          input logic [1:0] burst, input int stall_beat, input int stall_len,
                          input bit rand_ready);
    int cyc, nbeats, stall_left;
    bit prev_hold;
    logic [DATA_W-1:0] p_data;
    logic p_last;
    logic [ID_W-1:0] p_id;
    obs_addr.delete(); obs_data.delete(); obs_id.delete();
    obs_last.delete(); obs_resp.delete(); obs_cyc.delete();
    timed_out = 0; hold_viol = 0; ar_busy = 0; first_valid_cyc = -1;
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARBURST = burst;
    ARSIZE = 3'($urandom_range(0, 7)); ARVALID = 1'b1;
    cyc = 0;
    while (!ARREADY && cyc < 20) begin @(posedge ACLK); #1; cyc++; end
    if (!ARREADY) begin timed_out = 1; ARVALID = 1'b0; return; end
    @(posedge ACLK); #1;
    ARVALID = 1'b0; ARID = ID_W'($urandom); ARADDR = ADDR_W'($urandom);
    ARLEN = 4'($urandom); ARBURST = 2'($urandom);
    cyc = 1; nbeats = 0; stall_left = stall_len; prev_hold = 0;
    p_data = '0; p_last = 1'b0; p_id = '0;
    while (nbeats <= len && cyc < 400) begin
      if (ARREADY) ar_busy++;
      if (prev_hold && (!RVALID || RDATA !== p_data || RLAST !== p_last || RID !== p_id || SRAM_CS))
        hold_viol++;
      if (SRAM_CS) obs_addr.push_back(SRAM_A);
      if (RVALID) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (nbeats == stall_beat && stall_left > 0) begin RREADY = 1'b0; stall_left--; end
        else if (rand_ready) RREADY = ($urandom_range(0, 2) != 0);
        else RREADY = 1'b1;
        if (RREADY) begin
          obs_data.push_back(RDATA); obs_id.push_back(RID); obs_last.push_back(RLAST);
          obs_resp.push_back(RRESP); obs_cyc.push_back(cyc);
          nbeats++;
        end
        prev_hold = !RREADY; p_data = RDATA; p_last = RLAST; p_id = RID;
      end else begin
        RREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_hold = 0;
      end
      @(posedge ACLK); #1; cyc++;
    end
    if (nbeats <= len) timed_out = 1;
    RREADY = 1'b1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    checks++; if (ARREADY !== 1'b1) begin errors++; $display("FAIL reset_arready got=%b exp=1", ARREADY); end
    checks++; if (RVALID !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", RVALID); end
    checks++; if (RLAST !== 1'b0) begin errors++; $display("FAIL reset_rlast got=%b exp=0", RLAST); end
    checks++; if (RID !== '0) begin errors++; $display("FAIL reset_rid got=%h exp=0", RID); end
    checks++; if (RDATA !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", RDATA); end
    checks++; if (RRESP !== 2'b00) begin errors++; $display("FAIL reset_rresp got=%b exp=00", RRESP); end
    checks++; if ({SRAM_CS, SRAM_OE} !== 2'b00) begin errors++; $display("FAIL reset_sram_strobe got=%b%b exp=00", SRAM_CS, SRAM_OE); end
    checks++; if (SRAM_A !== '0) begin errors++; $display("FAIL reset_sram_a got=%h exp=0", SRAM_A); end
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    checks++; if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin errors++; $display("FAIL idle_after_reset arready=%b rvalid=%b exp 1/0", ARREADY, RVALID); end
  endtask

  task automatic test_directed();
    logic [ID_W-1:0]   c_id    [7] = '{8'h05, 8'hA1, 8'h33, 8'h7F, 8'h02, 8'hFF, 8'h5C};
    logic [ADDR_W-1:0] c_addr  [7] = '{32'h0000_0010, 32'h0000_0038, 32'h0000_0020, 32'h0000_FFFC,
                                       32'h0000_003C, 32'hABCD_0008, 32'h0000_01C4};
    int                c_len   [7] = '{3, 3, 2, 1, 2, 1, 7};
    logic [1:0]        c_burst [7] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    int                c_exp   [7][8] = '{'{4, 5, 6, 7, 0, 0, 0, 0}, '{14, 15, 12, 13, 0, 0, 0, 0},
                                          '{8, 8, 8, 0, 0, 0, 0, 0}, '{16383, 0, 0, 0, 0, 0, 0, 0},
                                          '{15, 16, 17, 0, 0, 0, 0, 0}, '{2, 3, 0, 0, 0, 0, 0, 0},
                                          '{113, 114, 115, 116, 117, 118, 119, 112}};
    logic [SRAM_AW-1:0] ea;
    logic el;
    for (int c = 0; c < 7; c++) begin
      do_burst(c_id[c], c_addr[c], c_len[c], c_burst[c], -1, 0, 1'b0);
      checks++; if (timed_out) begin errors++; $display("FAIL dir%0d_timeout beats=%0d exp=%0d", c, obs_data.size(), c_len[c] + 1); end
      checks++; if (obs_addr.size() != c_len[c] + 1) begin errors++; $display("FAIL dir%0d_strobes got=%0d exp=%0d", c, obs_addr.size(), c_len[c] + 1); end
      checks++; if (first_valid_cyc != 2) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=2", c, first_valid_cyc); end
      checks++; if (ar_busy != 0) begin errors++; $display("FAIL dir%0d_arready_in_burst got=%0d exp=0", c, ar_busy); end
      for (int i = 0; i < obs_data.size() && i <= c_len[c]; i++) begin
        ea = SRAM_AW'(c_exp[c][i]);
        el = (i == c_len[c]);
        checks++;
        if (i >= obs_addr.size() || obs_addr[i] !== ea || obs_data[i] !== mem[ea] || obs_id[i] !== c_id[c] ||
            obs_last[i] !== el || obs_resp[i] !== 2'b00 || obs_cyc[i] != 2 + 2 * i) begin
          errors++;
          $display("FAIL dir%0d_beat%0d addr=%h/%h data=%h/%h id=%h/%h last=%b/%b resp=%b/00 cyc=%0d/%0d",
                   c, i, (i < obs_addr.size()) ? obs_addr[i] : '0, ea, obs_data[i], mem[ea],
                   obs_id[i], c_id[c], obs_last[i], el, obs_resp[i], obs_cyc[i], 2 + 2 * i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a;
    logic [SRAM_AW-1:0] ea;
    int ecyc [4] = '{2, 9, 11, 13};
    a = ADDR_W'($urandom);
    do_burst(8'h3C, a, 3, 2'b01, 1, 5, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout beats=%0d exp=4", obs_data.size()); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold_violations got=%0d exp=0", hold_viol); end
    checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL bp_strobes got=%0d exp=4", obs_addr.size()); end
    for (int i = 0; i < obs_data.size() && i < 4; i++) begin
      ea = model_addr(a, 3, 2'b01, i);
      checks++;
      if (obs_data[i] !== mem[ea] || obs_last[i] !== (i == 3) || obs_id[i] !== 8'h3C || obs_cyc[i] != ecyc[i]) begin
        errors++;
        $display("FAIL bp_beat%0d data=%h/%h last=%b/%b id=%h/3c cyc=%0d/%0d", i, obs_data[i], mem[ea],
                 obs_last[i], (i == 3), obs_id[i], obs_cyc[i], ecyc[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc, nvalid, stray;
    logic [ADDR_W-1:0] a;
    logic [SRAM_AW-1:0] ea;
    ARID = 8'h09; ARADDR = 32'h0000_0100; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1; RREADY = 1'b1;
    cyc = 0;
    while (!ARREADY && cyc < 20) begin @(posedge ACLK); #1; cyc++; end
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    nvalid = 0; cyc = 0;
    while (nvalid < 2 && cyc < 50) begin
      if (RVALID) nvalid++;
      if (nvalid < 2) begin @(posedge ACLK); #1; cyc++; end
    end
    checks++; if (nvalid != 2) begin errors++; $display("FAIL rst_mid_reach_beat2 got=%0d exp=2", nvalid); end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checks++; if (RVALID !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid got=%b exp=0", RVALID); end
    checks++; if (ARREADY !== 1'b1) begin errors++; $display("FAIL rst_mid_arready got=%b exp=1", ARREADY); end
    checks++; if (SRAM_CS !== 1'b0) begin errors++; $display("FAIL rst_mid_sram_cs got=%b exp=0", SRAM_CS); end
    ARESET = 1'b0;
    stray = 0;
    repeat (6) begin
      @(posedge ACLK); #1;
      if (RVALID || SRAM_CS || !ARREADY) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_stray_activity got=%0d exp=0", stray); end
    a = ADDR_W'($urandom);
    do_burst(8'h44, a, 1, 2'b01, -1, 0, 1'b0);
    checks++; if (timed_out || obs_data.size() != 2) begin errors++; $display("FAIL rst_mid_new_burst beats=%0d exp=2", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 2; i++) begin
      ea = model_addr(a, 1, 2'b01, i);
      checks++;
      if (obs_data[i] !== mem[ea] || obs_id[i] !== 8'h44 || obs_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL rst_mid_new_beat%0d data=%h/%h id=%h/44 last=%b/%b", i, obs_data[i], mem[ea],
                 obs_id[i], obs_last[i], (i == 1));
      end
    end
  endtask

  task automatic test_random();
    logic [ID_W-1:0] id;
    logic [ADDR_W-1:0] a;
    logic [1:0] b;
    logic [SRAM_AW-1:0] ea;
    int len;
    for (int n = 0; n < 30; n++) begin
      id  = ID_W'($urandom);
      a   = ADDR_W'($urandom);
      b   = 2'($urandom);
      len = $urandom_range(0, 15);
      do_burst(id, a, len, b, -1, 0, 1'b1);
      checks++; if (timed_out) begin errors++; $display("FAIL rnd%0d_timeout beats=%0d exp=%0d", n, obs_data.size(), len + 1); end
      checks++; if (hold_viol != 0 || ar_busy != 0) begin errors++; $display("FAIL rnd%0d_protocol hold=%0d arready=%0d exp 0/0", n, hold_viol, ar_busy); end
      checks++; if (obs_addr.size() != len + 1) begin errors++; $display("FAIL rnd%0d_strobes got=%0d exp=%0d", n, obs_addr.size(), len + 1); end
      for (int i = 0; i < obs_data.size() && i <= len; i++) begin
        ea = model_addr(a, len, b, i);
        checks++;
        if (i >= obs_addr.size() || obs_addr[i] !== ea || obs_data[i] !== mem[ea] || obs_id[i] !== id ||
            obs_last[i] !== (i == len) || obs_resp[i] !== 2'b00) begin
          errors++;
          $display("FAIL rnd%0d_beat%0d burst=%b len=%0d addr=%h/%h data=%h/%h id=%h/%h last=%b/%b",
                   n, i, b, len, (i < obs_addr.size()) ? obs_addr[i] : '0, ea, obs_data[i], mem[ea],
                   obs_id[i], id, obs_last[i], (i == len));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
